buffer_pser: RTL and testbench

Parametrised parallel-in/serial-out frame buffer, successor to the fixed 4-bit × 16-word serialiser. It collects DEPTH words of IN_W bits from an upstream producer and streams the frame out one bit per cycle. A ping-pong pair of banks lets the next frame load while the current one drains. Valid/ready handshakes on both sides replace the old sticky enable, so it sits between any word-wide source and a bit-serial link.

---
 rtl/buffer_pser_pkg.sv | 22 ++
 rtl/buffer_pser_bank.sv | 45 ++++
 rtl/buffer_pser.sv | 176 +++++++++++++++++
 tb/tb_buffer_pser.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/buffer_pser_pkg.sv
// rtl/buffer_pser_pkg.sv - shared FSM state type and frame-bit mapping helpers for buffer_pser
package buffer_pser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic int frame_bits(input int depth, input int in_w);
    return depth * in_w;
  endfunction

  function automatic int word_of(input int k, input int in_w);
    return k / in_w;
  endfunction

  function automatic int bit_of(input int k, input int in_w, input bit msb_first);
    return msb_first ? (in_w - 1 - (k % in_w)) : (k % in_w);
  endfunction

endpackage

// File: rtl/buffer_pser_bank.sv
// rtl/buffer_pser_bank.sv - one DEPTH x IN_W frame bank with bit-read mux
// Optional running parity accumulator under BUFFER_PSER_PARITY_EN.
module buffer_pser_bank
  import buffer_pser_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(frame_bits(DEPTH, IN_W))
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [IN_W-1:0]  wr_data,
  input  logic [CNT_W-1:0] rd_bit,
  output logic             rd_data
`ifdef BUFFER_PSER_PARITY_EN
  ,
  output logic             parity
`endif
);

  // Contents are deliberately not reset; the full flags gate every read.
  logic [IN_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] word_sel;
  logic [IN_W-1:0]  shifted;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_comb begin
    word_sel = IDX_W'(word_of(int'(rd_bit), IN_W));
    shifted  = mem[word_sel] >> bit_of(int'(rd_bit), IN_W, MSB_FIRST != 0);
    rd_data  = shifted[0];
  end

`ifdef BUFFER_PSER_PARITY_EN
  always_ff @(posedge clk) begin
    if (wr_en) parity <= (wr_idx == '0) ? ^wr_data : (parity ^ (^wr_data));
  end
`endif

endmodule

// File: rtl/buffer_pser.sv
// rtl/buffer_pser.sv - ping-pong parallel-in/serial-out frame buffer (top)
// BUFFER_PSER_PARITY_EN appends an even-parity bit to every frame.
module buffer_pser
  import buffer_pser_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            data_out,
  output logic            out_last
);

  localparam int FB    = frame_bits(DEPTH, IN_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(FB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(FB - 2);

  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       full;
  logic [1:0]       full_n;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             dout_n;
  logic             valid_n;
  logic             last_n;
  logic             rd_bank_n;
  logic             rd_clr;
  logic             frame_end;
  logic             free;
  logic             wr_fire;
  logic             wr_done;
  logic [1:0]       bank_bit;
  logic [CNT_W-1:0] rd_sel [2];
`ifdef BUFFER_PSER_PARITY_EN
  logic [1:0]       bank_par;
`endif

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_idx == IDX_LAST);
  assign free     = !out_valid || out_ready;

  // The active bank is addressed at the next bit; the idle bank always at bit 0 for a gapless handoff.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign rd_sel[b] = (rd_bank == 1'(b) && state == SHIFT) ? cnt + 1'b1 : '0;

    buffer_pser_bank #(
      .IN_W     (IN_W),
      .DEPTH    (DEPTH),
      .MSB_FIRST(MSB_FIRST)
    ) u_bank (
      .clk    (clk),
      .wr_en  (wr_fire && wr_bank == 1'(b)),
      .wr_idx (wr_idx),
      .wr_data(data_in),
      .rd_bit (rd_sel[b]),
      .rd_data(bank_bit[b])
`ifdef BUFFER_PSER_PARITY_EN
      ,
      .parity (bank_par[b])
`endif
    );
  end

  always_comb begin
    full_n = full;
    if (rd_clr)  full_n[rd_bank] = 1'b0;
    if (wr_done) full_n[wr_bank] = 1'b1;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dout_n    = data_out;
    valid_n   = out_valid;
    last_n    = out_last;
    rd_bank_n = rd_bank;
    rd_clr    = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          dout_n  = bank_bit[rd_bank];
          valid_n = 1'b1;
          last_n  = 1'b0;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (free) begin
          if (cnt == CNT_LAST) begin
`ifdef BUFFER_PSER_PARITY_EN
            dout_n  = bank_par[rd_bank];
            last_n  = 1'b1;
            state_n = PAR;
`else
            frame_end = 1'b1;
`endif
          end else begin
            dout_n = bank_bit[rd_bank];
            cnt_n  = cnt + 1'b1;
`ifdef BUFFER_PSER_PARITY_EN
            last_n = 1'b0;
`else
            last_n = (cnt == CNT_PEN);
`endif
          end
        end
      end
`ifdef BUFFER_PSER_PARITY_EN
      PAR: begin
        if (free) frame_end = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase

    if (frame_end) begin
      rd_clr    = 1'b1;
      rd_bank_n = ~rd_bank;
      last_n    = 1'b0;
      cnt_n     = '0;
      if (full[~rd_bank]) begin
        dout_n  = bank_bit[~rd_bank];
        valid_n = 1'b1;
        state_n = SHIFT;
      end else begin
        dout_n  = 1'b0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      full      <= 2'b00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_out  <= dout_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      rd_bank   <= rd_bank_n;
      full      <= full_n;
      if (wr_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
    end
  end

endmodule

// File: tb/tb_buffer_pser.sv
// tb/tb_buffer_pser.sv - directed self-checking bench for buffer_pser
module tb_buffer_pser;

`ifdef BUFFER_PSER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = 64 + PAR;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, data_out, out_last;
  logic [3:0] data_in;
  logic       v2, r2, ov2, or2, dout2, last2;
  logic [3:0] d2;

  always #5 clk = ~clk;

  buffer_pser #(.IN_W(4), .DEPTH(16), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_last(out_last)
  );

  buffer_pser #(.IN_W(4), .DEPTH(2), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .data_in(d2),
    .out_valid(ov2), .out_ready(or2), .data_out(dout2), .out_last(last2)
  );

  int passed = 0;
  int total  = 0;

  logic [3:0] wq[$];
  logic [3:0] sent[$];
  bit         obits[$];
  bit         olast[$];
  int accepted, first_drop_acc, first_valid_cyc, last_acc_cyc, gaps, pend, hold_viol;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1
  task automatic run(input int ncyc, input int mode);
    bit pv_stall = 1'b0;
    bit pd = 1'b0;
    bit pl = 1'b0;
    accepted = 0; first_drop_acc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
    gaps = 0; pend = 0; hold_viol = 0;
    obits.delete(); olast.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (pv_stall && (data_out !== pd || out_last !== pl || out_valid !== 1'b1)) hold_viol++;
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = c;
        gaps += pend;
        pend = 0;
      end else if (first_valid_cyc >= 0) begin
        pend++;
      end
      if (!in_ready && first_drop_acc < 0) first_drop_acc = accepted;
      in_valid = (wq.size() > 0);
      data_in  = in_valid ? wq[0] : 4'h0;
      if (in_valid && in_ready) begin
        void'(wq.pop_front());
        accepted++;
        last_acc_cyc = c;
      end
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (out_valid && out_ready) begin
        obits.push_back(data_out);
        olast.push_back(out_last);
      end
      pv_stall = out_valid && !out_ready;
      pd = data_out;
      pl = out_last;
    end
  endtask

  task automatic check_frames(input string tag, input logic [3:0] src[$]);
    int nfr  = src.size() / 16;
    int bad  = 0;
    int badl = 0;
    check({tag, "_len"}, obits.size(), nfr * FLEN);
    for (int i = 0; i < obits.size(); i++) begin
      int fr = i / FLEN;
      int k  = i % FLEN;
      bit e;
      logic [3:0] w;
      if (fr >= nfr) break;
      if (k < 64) begin
        w = src[fr*16 + k/4];
        e = w[k%4];
      end else begin
        e = 1'b0;
        for (int j = 0; j < 16; j++) begin
          w = src[fr*16 + j];
          e = e ^ (^w);
        end
      end
      if (obits[i] !== e) bad++;
      if (olast[i] !== (k == FLEN - 1)) badl++;
    end
    check({tag, "_bits"}, bad, 0);
    check({tag, "_last"}, badl, 0);
  endtask

  initial begin
    logic [7:0] pk;
    bit q2[$];
    int n2;
    rst = 1'b1; in_valid = 1'b0; data_in = 4'h0; out_ready = 1'b0;
    v2 = 1'b0; d2 = 4'h0; or2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // single frame, words 0..F
    sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back(4'(i));
    wq = sent;
    run(90, 0);
    check_frames("single", sent);
    pk = '0;
    for (int i = 0; i < 8 && i < obits.size(); i++) pk[i] = obits[i];
    check("single_first8", pk, 8'h10);
    pk = '0;
    for (int i = 0; i < 4 && 60 + i < obits.size(); i++) pk[i] = obits[60 + i];
    check("single_last4", pk, 8'h0f);
    check("single_latency", first_valid_cyc - last_acc_cyc, 2);

    // ping-pong, 48 words streamed continuously
    sent.delete();
    for (int i = 0; i < 48; i++) sent.push_back(4'((i * 5 + 3) & 15));
    wq = sent;
    run(250, 0);
    check_frames("pingpong", sent);
    check("pingpong_drop_at", first_drop_acc, 32);
    check("pingpong_accepted", accepted, 48);
    check("pingpong_gaps", gaps, 0);

    // backpressure 1,0,0,1
    sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back(4'((i * 11 + 6) & 15));
    wq = sent;
    run(300, 1);
    check_frames("bp", sent);
    check("bp_hold", hold_viol, 0);

    // reset mid-frame
    wq.delete();
    for (int i = 0; i < 23; i++) wq.push_back(4'hf);
    run(30, 0);
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_data_out", data_out, 1'b0);
    check("midrst_out_last", out_last, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back(4'ha);
    wq = sent;
    run(90, 0);
    check_frames("postrst", sent);

    // MSB_FIRST=1, DEPTH=2: words 0x8, 0x3 -> 1,0,0,0, 0,0,1,1
    n2 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      v2  = (n2 < 2);
      d2  = (n2 == 0) ? 4'h8 : 4'h3;
      or2 = 1'b1;
      if (v2 && r2) n2++;
      if (ov2 && or2) q2.push_back(dout2);
    end
    @(negedge clk);
    v2 = 1'b0;
    check("msb_len", q2.size(), 8 + PAR);
    pk = '0;
    for (int i = 0; i < 8 && i < q2.size(); i++) pk[i] = q2[i];
    check("msb_bits", pk, 8'hc1);
`ifdef BUFFER_PSER_PARITY_EN
    if (q2.size() > 8) check("msb_parity", q2[8], 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
